ps2_device_tx: RTL and testbench



---
 rtl/ps2_device_tx.sv | 205 ++++++++++++++++++++
 tb/tb_ps2_device_tx.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_device_tx.sv
// rtl/ps2_device_tx.sv - PS/2 device-side byte transmitter with open-drain clock/data drive.
// Define PS2DEV_FIFO_EN for a 4-entry byte FIFO; otherwise a single holding register is used.
module ps2_device_tx #(
    parameter int CLKDIV_HALF     = 1120,
    parameter int BUS_IDLE_CYCLES = 1400
) (
    input  logic       clk,
    input  logic       rst_n,
    inout  wire        clkps2,
    inout  wire        dataps2,
    input  logic [7:0] data,
    input  logic       dataload,
    output logic       ready,
    output logic       busy,
    output logic       sent,
    output logic       aborted,
    output logic       overflow
);
    localparam int PW = (CLKDIV_HALF > 4) ? $clog2(CLKDIV_HALF) : 2;
    localparam int IW = (BUS_IDLE_CYCLES > 4) ? $clog2(BUS_IDLE_CYCLES) : 2;
    localparam logic [PW-1:0] PH_LAST   = PW'(CLKDIV_HALF - 1);
    localparam logic [PW-1:0] SETTLE    = PW'(2);
    localparam logic [IW-1:0] IDLE_LAST = IW'(BUS_IDLE_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, WAIT_BUS, SETUP, LOW, HIGH, DONE} state_t;

    state_t        state;
    logic [PW-1:0] ph;
    logic [IW-1:0] idle_cnt;
    logic [3:0]    bit_idx;
    logic [3:0]    next_idx;
    logic [10:0]   frame;
    logic          clk_low;
    logic          dat_low;
    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          sclk;
    logic          sdat;
    logic          q_empty;
    logic          q_full;
    logic          push;
    logic          pop;
    logic [7:0]    q_head;

    assign clkps2  = clk_low ? 1'b0 : 1'bz;
    assign dataps2 = dat_low ? 1'b0 : 1'bz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], clkps2};
            dat_sync <= {dat_sync[0], dataps2};
        end
    end

    assign sclk     = clk_sync[1];
    assign sdat     = dat_sync[1];
    assign pop      = (state == DONE);
    assign push     = dataload && (!q_full || pop);
    assign next_idx = bit_idx + 4'd1;
    assign ready    = !q_full;
    assign busy     = !q_empty || (state != IDLE);

`ifdef PS2DEV_FIFO_EN
    logic [7:0] mem [4];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] count;

    assign q_empty = (count == 3'd0);
    assign q_full  = count[2];
    assign q_head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: ;
            endcase
        end
    end
`else
    logic [7:0] hold;
    logic       hold_full;

    assign q_empty = !hold_full;
    assign q_full  = hold_full;
    assign q_head  = hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold      <= 8'd0;
            hold_full <= 1'b0;
        end else begin
            if (push) hold <= data;
            if (push)     hold_full <= 1'b1;
            else if (pop) hold_full <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) overflow <= 1'b0;
        else        overflow <= dataload && q_full && !pop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ph       <= '0;
            idle_cnt <= '0;
            bit_idx  <= 4'd0;
            frame    <= 11'd0;
            clk_low  <= 1'b0;
            dat_low  <= 1'b0;
            sent     <= 1'b0;
            aborted  <= 1'b0;
        end else begin
            sent    <= 1'b0;
            aborted <= 1'b0;
            case (state)
                IDLE: begin
                    if (!q_empty || push) begin
                        idle_cnt <= '0;
                        state    <= WAIT_BUS;
                    end
                end
                WAIT_BUS: begin
                    if (sclk && sdat) begin
                        if (idle_cnt == IDLE_LAST) begin
                            frame   <= {1'b1, ~^q_head, q_head, 1'b0};
                            bit_idx <= 4'd0;
                            ph      <= '0;
                            dat_low <= 1'b1;
                            state   <= SETUP;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end else begin
                        idle_cnt <= '0;
                    end
                end
                SETUP: begin
                    if (ph == PH_LAST) begin
                        ph      <= '0;
                        clk_low <= 1'b1;
                        state   <= LOW;
                    end else begin
                        ph <= ph + 1'b1;
                    end
                end
                LOW: begin
                    // The rising edge after the stop bit ends the frame; data for the next bit is set up here.
                    if (ph == PH_LAST) begin
                        ph      <= '0;
                        clk_low <= 1'b0;
                        if (bit_idx == 4'd10) begin
                            dat_low <= 1'b0;
                            state   <= DONE;
                        end else begin
                            dat_low <= ~frame[next_idx];
                            state   <= HIGH;
                        end
                    end else begin
                        ph <= ph + 1'b1;
                    end
                end
                HIGH: begin
                    if (ph >= SETTLE && !sclk && bit_idx <= 4'd9) begin
                        clk_low  <= 1'b0;
                        dat_low  <= 1'b0;
                        aborted  <= 1'b1;
                        idle_cnt <= '0;
                        state    <= WAIT_BUS;
                    end else if (ph == PH_LAST) begin
                        ph      <= '0;
                        bit_idx <= next_idx;
                        clk_low <= 1'b1;
                        state   <= LOW;
                    end else begin
                        ph <= ph + 1'b1;
                    end
                end
                DONE: begin
                    sent  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_device_tx.sv
// tb/tb_ps2_device_tx.sv - directed self-checking bench for ps2_device_tx with a PS/2 host model.
module tb_ps2_device_tx;
    localparam int H = 8;
    localparam int B = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    wire        clkps2;
    wire        dataps2;
    logic [7:0] tx_byte = 8'd0;
    logic       dataload = 1'b0;
    logic       ready;
    logic       busy;
    logic       sent;
    logic       aborted;
    logic       overflow;
    logic       host_clk_low = 1'b0;

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int sent_cnt = 0;
    int aborted_cnt = 0;
    int fall_total = 0;
    int dchg_total = 0;
    logic prev_c = 1'b1;
    logic prev_d = 1'b1;
    logic rx_mem [512];
    int   fall_cyc [512];
    int   dchg_cyc [512];

    pullup (clkps2);
    pullup (dataps2);
    assign clkps2 = host_clk_low ? 1'b0 : 1'bz;

    ps2_device_tx #(.CLKDIV_HALF(H), .BUS_IDLE_CYCLES(B)) dut (
        .clk(clk), .rst_n(rst_n), .clkps2(clkps2), .dataps2(dataps2),
        .data(tx_byte), .dataload(dataload), .ready(ready), .busy(busy),
        .sent(sent), .aborted(aborted), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Host side: sample data on device-generated clock falls, log data-line changes.
    always @(negedge clk) begin
        if (prev_c === 1'b1 && clkps2 === 1'b0 && !host_clk_low && fall_total < 512) begin
            rx_mem[fall_total]   = dataps2;
            fall_cyc[fall_total] = cyc;
            fall_total++;
        end
        if (prev_d !== dataps2 && dchg_total < 512) begin
            dchg_cyc[dchg_total] = cyc;
            dchg_total++;
        end
        prev_c = clkps2;
        prev_d = dataps2;
        if (sent === 1'b1) sent_cnt++;
        if (aborted === 1'b1) aborted_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [7:0] b);
        tx_byte  = b;
        dataload = 1'b1;
        tick();
        dataload = 1'b0;
    endtask

    task automatic wait_start(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (dataps2 === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_sent(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (sent === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [10:0] frame_at(input int b);
        logic [10:0] f;
        f = '0;
        for (int k = 0; k < 11; k++) if (b + k < 512) f[k] = rx_mem[b + k];
        return f;
    endfunction

    function automatic int min_gap(input int fb, input int db);
        int m;
        m = 1000;
        for (int i = fb; i < fall_total && i < fb + 11; i++) begin
            for (int j = db; j < dchg_total; j++) begin
                int d;
                d = fall_cyc[i] - dchg_cyc[j];
                if (d < 0) d = -d;
                if (d < m) m = d;
            end
        end
        return m;
    endfunction

    initial begin
        int t0, ts, r0, fb, db, base, ab_at;
        bit ok;
        logic [10:0] f;
        logic [7:0] exp_b [4];

        repeat (3) tick();
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_sent", sent, 0);
        check("rst_aborted", aborted, 0);
        check("rst_overflow", overflow, 0);
        check("rst_clk_z", clkps2, 1);
        check("rst_dat_z", dataps2, 1);
        rst_n = 1'b1;
        repeat (2) tick();

        // 8'h1C with a passive host
        fb = fall_total;
        load(8'h1C);
        t0 = cyc;
        check("t1_busy", busy, 1);
        wait_start(B + 10, ok);
        check("t1_start_seen", ok, 1);
        check("t1_start_latency", cyc - t0, B);
        ts = cyc;
        wait_sent(24 * H + 10, ok);
        check("t1_sent_seen", ok, 1);
        check("t1_frame_time", cyc - ts, 22 * H + 1);
        check("t1_bits", frame_at(fb), 11'h438);
        check("t1_nbits", fall_total - fb, 11);
        check("t1_busy_done", busy, 0);
        tick();
        check("t1_sent_once", sent_cnt, 1);

        // 8'hF0: parity 1 and data edges away from clock falls
        fb = fall_total;
        db = dchg_total;
        load(8'hF0);
        wait_sent(B + 24 * H + 10, ok);
        check("t2_sent_seen", ok, 1);
        f = frame_at(fb);
        check("t2_bits", f, 11'h7E0);
        check("t2_parity", f[9], 1);
        check("t2_min_gap", min_gap(fb, db), H);

        // host holds the clock low before the load, then releases it
        host_clk_low = 1'b1;
        repeat (5) tick();
        fb = fall_total;
        load(8'h1C);
        ab_at = 0;
        repeat (3 * B) begin
            tick();
            if (dataps2 !== 1'b1) ab_at++;
        end
        check("t3_no_activity", ab_at, 0);
        check("t3_busy_held", busy, 1);
        host_clk_low = 1'b0;
        r0 = cyc;
        wait_start(B + 10, ok);
        check("t3_start_seen", ok, 1);
        check("t3_start_after_release", cyc - r0, B + 2);
        wait_sent(24 * H + 10, ok);
        check("t3_sent_seen", ok, 1);
        check("t3_bits", frame_at(fb), 11'h438);

        // host inhibit in the high half after bit 4, then retransmission
        fb = fall_total;
        load(8'h1C);
        wait_start(B + 10, ok);
        check("t4_start_seen", ok, 1);
        ok = 1'b0;
        for (int i = 0; i < 30 * H; i++) begin
            tick();
            if (fall_total - fb == 5 && clkps2 === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check("t4_high_after_bit4", ok, 1);
        repeat (3) tick();
        host_clk_low = 1'b1;
        ab_at = 0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            if (aborted === 1'b1 && ab_at == 0) ab_at = i;
        end
        check("t4_abort_latency", ab_at, 3);
        check("t4_dat_released", dataps2, 1);
        check("t4_byte_kept", busy, 1);
        repeat (5) tick();
        host_clk_low = 1'b0;
        r0 = cyc;
        fb = fall_total;
        tick();
        check("t4_clk_released", clkps2, 1);
        wait_start(B + 10, ok);
        check("t4_restart_seen", ok, 1);
        check("t4_restart_latency", cyc - r0, B + 2);
        wait_sent(24 * H + 10, ok);
        check("t4_sent_seen", ok, 1);
        check("t4_bits", frame_at(fb), 11'h438);
        tick();
        check("t4_aborted_once", aborted_cnt, 1);
        check("t4_sent_total", sent_cnt, 4);

        // queue full behaviour
        base = sent_cnt;
`ifdef PS2DEV_FIFO_EN
        exp_b = '{8'h12, 8'h34, 8'h56, 8'h78};
        load(8'h12);
        load(8'h34);
        load(8'h56);
        load(8'h78);
        check("q_ready_full", ready, 0);
        check("q_no_overflow", overflow, 0);
        load(8'h9A);
        check("q_overflow", overflow, 1);
        tick();
        check("q_overflow_pulse", overflow, 0);
        for (int k = 0; k < 4; k++) begin
            fb = fall_total;
            wait_sent(B + 24 * H + 10, ok);
            check("q_sent_seen", ok, 1);
            f = frame_at(fb);
            check("q_byte", f[8:1], exp_b[k]);
            check("q_busy", busy, (k == 3) ? 0 : 1);
        end
        tick();
        check("q_sent_count", sent_cnt - base, 4);
`else
        load(8'h12);
        check("q_ready_full", ready, 0);
        check("q_no_overflow", overflow, 0);
        load(8'h34);
        check("q_overflow", overflow, 1);
        tick();
        check("q_overflow_pulse", overflow, 0);
        fb = fall_total;
        wait_sent(B + 24 * H + 10, ok);
        check("q_sent_seen", ok, 1);
        f = frame_at(fb);
        check("q_byte", f[8:1], 8'h12);
        check("q_busy", busy, 0);
        tick();
        check("q_sent_count", sent_cnt - base, 1);
`endif

        // reset during bit 6
        fb = fall_total;
        load(8'h1C);
        ok = 1'b0;
        for (int i = 0; i < B + 30 * H; i++) begin
            tick();
            if (fall_total - fb == 7) begin
                ok = 1'b1;
                break;
            end
        end
        check("t6_bit6_seen", ok, 1);
        check("t6_clk_low", clkps2, 0);
        check("t6_dat_low", dataps2, 0);
        base = sent_cnt;
        rst_n = 1'b0;
        #1;
        check("t6_clk_z", clkps2, 1);
        check("t6_dat_z", dataps2, 1);
        check("t6_busy", busy, 0);
        check("t6_ready", ready, 1);
        check("t6_sent", sent, 0);
        tick();
        rst_n = 1'b1;
        repeat (B + 24 * H) tick();
        check("t6_no_sent", sent_cnt - base, 0);
        check("t6_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
